// File: rtl/plate_char_capture.sv
// plate_char_capture: captures seven plate character glyph bitmaps from a binarized
// frame and streams them out row by row under valid/ready.
module plate_char_capture #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        per_frame_vsync,
   input  logic        per_frame_href,
   input  logic        per_frame_clken,
   input  logic        per_frame_bit,
   input  logic [9:0]  plate_boarder_up,
   input  logic [9:0]  plate_boarder_left,
   input  logic        plate_exist_flag,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [2:0]  out_char_idx,
   output logic [4:0]  out_row,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic        frame_dropped
);
   typedef enum logic [1:0] {IDLE, CAPTURE, READOUT} state_t;
   localparam logic [10:0] W11 = 11'(IMG_W);
   localparam logic [10:0] H11 = 11'(IMG_H);
   state_t state, state_nx;
   logic vs_r, vs_rr, hr_r, hr_rr, ck_r, bit_r;
   logic [9:0] x, y;
   logic [10:0] top, left, dx, dy;
   logic [7:0] rd_idx, wr_idx;
   logic [2:0] k;
   logic [4:0] c;
   logic frame_start, frame_end, line_end, in_win, clr, accept;
   logic [31:0] mem [0:223];
   assign frame_start = vs_rr & ~vs_r;
   assign frame_end = ~vs_rr & vs_r;
   assign line_end = hr_rr & ~hr_r;
   assign clr = (state == IDLE) && frame_start && plate_exist_flag;
   assign accept = out_valid && out_ready;
   assign out_char_idx = rd_idx[7:5];
   assign out_row = rd_idx[4:0];
   // dx spans the 128 columns of all seven cells; cell 0 is 32 wide, the rest 16
   always_comb begin
      dx = {1'b0, x} - left;
      dy = {1'b0, y} - top;
      in_win = ({1'b0, x} >= left) && (dx < 11'd128) && ({1'b0, y} >= top) && (dy < 11'd32)
               && ({1'b0, x} < W11) && ({1'b0, y} < H11);
      k = (dx[6:5] == 2'b00) ? 3'd0 : dx[6:4] - 3'd1;
      c = (dx[6:5] == 2'b00) ? dx[4:0] : {1'b0, dx[3:0]};
      wr_idx = {k, dy[4:0]};
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = (frame_start && plate_exist_flag) ? CAPTURE : IDLE;
         CAPTURE: state_nx = frame_end ? READOUT : CAPTURE;
         READOUT: state_nx = (accept && out_last) ? IDLE : READOUT;
         default: state_nx = IDLE;
      endcase
      out_valid = (state == READOUT);
      out_last = out_valid && (rd_idx == 8'd223);
      out_data = out_valid ? mem[rd_idx] : 32'd0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         {vs_r, vs_rr, hr_r, hr_rr, ck_r, bit_r} <= '0;
         x <= '0;
         y <= '0;
         top <= '0;
         left <= '0;
         rd_idx <= '0;
         frame_dropped <= 1'b0;
      end else begin
         state <= state_nx;
         vs_r <= per_frame_vsync;
         vs_rr <= vs_r;
         hr_r <= per_frame_href;
         hr_rr <= hr_r;
         ck_r <= per_frame_clken;
         bit_r <= per_frame_bit;
         frame_dropped <= (state == READOUT) && frame_start;
         if (frame_start) begin
            x <= '0;
            y <= '0;
         end else if (line_end) begin
            x <= '0;
            y <= y + 10'd1;
         end else if (ck_r) begin
            x <= x + 10'd1;
         end
         if (clr) begin
            top <= {1'b0, plate_boarder_up};
            left <= {1'b0, plate_boarder_left};
         end
         if (state == CAPTURE && frame_end) rd_idx <= '0;
         else if (accept) rd_idx <= out_last ? 8'd0 : rd_idx + 8'd1;
      end
   end
   // Column 0 is the MSB, so the bit position is the inverted column
   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 224; i++) mem[i] <= '0;
      end else if (state == CAPTURE && ck_r && in_win) begin
         mem[wr_idx][~c] <= bit_r;
      end
   end
endmodule

// File: tb/tb_plate_char_capture.sv
// tb_plate_char_capture: directed frames with hand-computed glyph words.
module tb_plate_char_capture;
   logic clk = 1'b0, rst = 1'b1;
   logic vsync = 1'b1, href = 1'b0, clken = 1'b0, pbit = 1'b0;
   logic [9:0] up = '0, left = '0;
   logic flag = 1'b0, out_ready = 1'b0;
   logic out_valid, out_last, frame_dropped;
   logic [2:0] out_char_idx;
   logic [4:0] out_row;
   logic [31:0] out_data;
   int n_chk = 0, n_pass = 0, drops = 0, widx = 0, cyc = 0;
   int cur_mode, cur_w, cur_h, cur_up, cur_left;
   logic [31:0] got_w [224];
   plate_char_capture dut (
      .clk(clk), .rst(rst), .per_frame_vsync(vsync), .per_frame_href(href),
      .per_frame_clken(clken), .per_frame_bit(pbit), .plate_boarder_up(up),
      .plate_boarder_left(left), .plate_exist_flag(flag), .out_valid(out_valid),
      .out_ready(out_ready), .out_char_idx(out_char_idx), .out_row(out_row),
      .out_data(out_data), .out_last(out_last), .frame_dropped(frame_dropped)
   );
   always #5 clk = ~clk;
   always @(negedge clk) if (frame_dropped) drops++;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   function automatic logic pix(input int mode, input int px, input int py);
      if (mode == 0) return px >= 4 && px < 36 && py >= 8 && py < 40;
      if (mode == 1) return px == 37 && py == 10;
      return 1'b1;
   endfunction
   function automatic logic [31:0] exp_word(input int idx);
      logic [31:0] w = '0;
      int kk = idx / 32, r = idx % 32, px, py;
      for (int cc = 0; cc < ((kk == 0) ? 32 : 16); cc++) begin
         px = (kk == 0) ? cur_left + cc : cur_left + 32 + 16 * (kk - 1) + cc;
         py = cur_up + r;
         if (px < 640 && py < 480 && px < cur_w && py < cur_h && pix(cur_mode, px, py))
            w[31 - cc] = 1'b1;
      end
      return w;
   endfunction
   task automatic gen_line(input int ly);
      href = 1'b1;
      for (int lx = 0; lx < cur_w; lx++) begin
         clken = 1'b1;
         pbit = pix(cur_mode, lx, ly);
         tick;
      end
      {href, clken, pbit} = '0;
      repeat (4) tick;
   endtask
   task automatic frame_begin(input int mode, input int w, input int h, input int u, input int l, input logic f);
      cur_mode = mode; cur_w = w; cur_h = h; cur_up = u; cur_left = l;
      up = 10'(u); left = 10'(l); flag = f;
      tick;
      vsync = 1'b0;
      repeat (4) tick;
   endtask
   task automatic gen_frame(input int mode, input int w, input int h, input int u, input int l, input logic f);
      out_ready = 1'b0;
      frame_begin(mode, w, h, u, l, f);
      for (int ly = 0; ly < h; ly++) begin
         if (ly == h / 2) begin
            flag = ~f; up = '0; left = '0;
         end
         gen_line(ly);
      end
      vsync = 1'b1;
      tick;
      check("lat1", out_valid, 0);
      tick;
      check("lat2", out_valid, f);
   endtask
   task automatic read_words(input int cnt, input bit rnd);
      int got = 0;
      logic hold = 1'b0;
      logic [31:0] hold_data = '0;
      cyc = 0;
      while (got < cnt && cyc < 5000) begin
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (hold) check("hold", out_data, hold_data);
         if (out_valid && out_ready) begin
            check("idx", {out_char_idx, out_row}, widx);
            check("data", out_data, exp_word(widx));
            check("last", out_last, widx == 223);
            got_w[widx] = out_data;
            widx++;
            got++;
         end
         hold = out_valid && !out_ready;
         hold_data = out_data;
         tick;
         cyc++;
      end
      out_ready = 1'b0;
      check("count", got, cnt);
   endtask
   initial begin
      int d0;
      logic seen;
      repeat (3) tick;
      check("rst_valid", out_valid, 0);
      check("rst_last", out_last, 0);
      check("rst_drop", frame_dropped, 0);
      check("rst_data", out_data, 0);
      check("rst_pos", {out_char_idx, out_row}, 0);
      rst = 1'b0;
      tick;
      gen_frame(0, 64, 48, 8, 4, 1'b1);
      widx = 0;
      read_words(224, 1'b0);
      check("min_cycles", cyc, 224);
      check("a_c0r0", got_w[0], 32'hFFFFFFFF);
      check("a_c0r31", got_w[31], 32'hFFFFFFFF);
      check("a_c1r0", got_w[32], 32'h0);
      check("a_c6r31", got_w[223], 32'h0);
      check("a_idle", out_valid, 0);
      gen_frame(1, 64, 48, 8, 4, 1'b1);
      widx = 0;
      read_words(224, 1'b1);
      check("b_c1r2", got_w[34], 32'h40000000);
      check("b_c1r1", got_w[33], 32'h0);
      check("b_c0r2", got_w[2], 32'h0);
      gen_frame(0, 64, 48, 8, 4, 1'b0);
      seen = 1'b0;
      repeat (20) begin
         seen |= out_valid;
         tick;
      end
      check("noflag", seen, 0);
      gen_frame(0, 64, 48, 8, 4, 1'b1);
      widx = 0;
      read_words(10, 1'b0);
      d0 = drops;
      flag = 1'b1;
      vsync = 1'b0;
      repeat (6) tick;
      check("drop_hold", out_data, exp_word(10));
      vsync = 1'b1;
      repeat (4) tick;
      check("drop_once", drops - d0, 1);
      check("drop_valid", out_valid, 1);
      check("drop_pos", {out_char_idx, out_row}, 10);
      read_words(214, 1'b0);
      gen_frame(2, 700, 34, 0, 620, 1'b1);
      widx = 0;
      read_words(224, 1'b0);
      check("e_c0r0", got_w[0], 32'hFFFFF000);
      check("e_c0r31", got_w[31], 32'hFFFFF000);
      check("e_c1r0", got_w[32], 32'h0);
      frame_begin(0, 64, 48, 8, 4, 1'b1);
      for (int ly = 0; ly < 12; ly++) gen_line(ly);
      rst = 1'b1;
      repeat (2) tick;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_pos", {out_char_idx, out_row}, 0);
      rst = 1'b0;
      for (int ly = 12; ly < 48; ly++) gen_line(ly);
      vsync = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         seen |= out_valid;
         tick;
      end
      check("mid_rst_idle", seen, 0);
      gen_frame(1, 64, 48, 8, 4, 1'b1);
      widx = 0;
      read_words(224, 1'b0);
      check("r_c1r2", got_w[34], 32'h40000000);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
